// File: rtl/i2c_master_fifo_seq.sv
// ---------------------------------------------------------------------------
// i2c_master_fifo_seq
// Wishbone-attached I2C transaction sequencer. Firmware loads the TX FIFO,
// programs WLEN/RLEN/SADR and issues a single GO. The sequencer then runs the
// whole write / repeated-start / read transaction by feeding
// i2c_master_byte_ctrl one byte command at a time. It generates ACK/NACK on
// reads and STOP on the last byte by itself.
//
// Ports
//   wb_clk_i, wb_rst_i       clock, synchronous active-high reset
//   wb_adr_i/dat_i/dat_o     Wishbone register select, write data, read data
//   wb_we_i/stb_i/cyc_i/ack_o Wishbone handshake (one wait state)
//   wb_inta_o                interrupt: IEN & (DONE | AL)
//   bc_en, bc_prer           core enable and prescaler for the byte controller
//   bc_start/stop/read/write byte command bits, held until bc_done
//   bc_ack_in, bc_din        ACK bit sent after a read (1 = NACK), TX byte
//   bc_done, bc_rxack        command-complete pulse, received ACK (1 = NACK)
//   bc_dout, bc_al, bc_busy  received byte, arbitration lost, bus busy
// ---------------------------------------------------------------------------
module i2c_master_fifo_seq #(
  parameter int          FIFO_DEPTH   = 8,
  parameter int          FIFO_AW      = 3,
  parameter int          LEN_W        = 8,
  parameter logic [15:0] DEFAULT_PRER = 16'hffff,
  parameter logic [6:0]  DEFAULT_SADR = 7'h7e
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [2:0]  wb_adr_i,
  input  logic [7:0]  wb_dat_i,
  output logic [7:0]  wb_dat_o,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        wb_inta_o,
  output logic        bc_en,
  output logic [15:0] bc_prer,
  output logic        bc_start,
  output logic        bc_stop,
  output logic        bc_read,
  output logic        bc_write,
  output logic        bc_ack_in,
  output logic [7:0]  bc_din,
  input  logic        bc_done,
  input  logic        bc_rxack,
  input  logic [7:0]  bc_dout,
  input  logic        bc_al,
  input  logic        bc_busy
);

  typedef enum logic [2:0] {IDLE, WADDR, WDATA, RADDR, RDATA, STOP} state_t;

  localparam logic [FIFO_AW:0]   FIFO_FULL = FIFO_DEPTH[FIFO_AW:0];
  localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);
  localparam logic [LEN_W-1:0]   LEN_ONE   = LEN_W'(1);
  localparam logic [LEN_W-1:0]   LEN_ZERO  = '0;

  state_t             state_reg;
  logic               en_reg, ien_reg;
  logic [6:0]         sadr_reg;
  logic [LEN_W-1:0]   wlen_reg, rlen_reg, w_cnt_reg, r_cnt_reg;
  logic               nostop_reg;
  logic               done_reg, nack_reg, al_reg;
  logic               rx_pop_ok_reg;

  logic [7:0]         tx_mem [FIFO_DEPTH];
  logic [7:0]         rx_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] tx_wr_ptr_reg, tx_rd_ptr_reg, rx_wr_ptr_reg, rx_rd_ptr_reg;
  logic [FIFO_AW:0]   tx_cnt_reg, rx_cnt_reg;

  // Bus-busy is informational only here; loss of the bus is reported via bc_al.
  logic               bc_busy_unused;
  assign bc_busy_unused = bc_busy;

  logic wb_req, wb_acc, wb_wr;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic cmd_active, busy, abort, w_last, r_last;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic go_accept, iack, flush;
  logic [7:0] status;

  assign wb_req     = wb_cyc_i & wb_stb_i & ~wb_ack_o;   // first cycle of access
  assign wb_acc     = wb_cyc_i & wb_stb_i & wb_ack_o;    // completing cycle
  assign wb_wr      = wb_acc & wb_we_i;

  assign tx_full    = (tx_cnt_reg == FIFO_FULL);
  assign tx_empty   = (tx_cnt_reg == '0);
  assign rx_full    = (rx_cnt_reg == FIFO_FULL);
  assign rx_empty   = (rx_cnt_reg == '0);

  assign cmd_active = bc_start | bc_stop | bc_read | bc_write;
  assign busy       = (state_reg != IDLE);
  // Arbitration loss or core disable kills a running transaction outright.
  assign abort      = busy & (bc_al | ~en_reg);
  assign w_last     = (w_cnt_reg == LEN_ONE);
  assign r_last     = (r_cnt_reg == LEN_ONE);

  assign go_accept  = wb_wr & (wb_adr_i == 3'd4) & wb_dat_i[7] & ~busy & en_reg;
  assign iack       = wb_wr & (wb_adr_i == 3'd4) & wb_dat_i[0];
  assign flush      = wb_wr & (wb_adr_i == 3'd2) & wb_dat_i[0] & ~busy;

  // The engine pops exactly when it issues a data write; these mirror the
  // command-issue conditions of the FSM below.
  assign tx_pop     = ~abort & (state_reg == WDATA) & ~cmd_active & ~tx_empty;
  assign rx_push    = ~abort & (state_reg == RDATA) & bc_read & bc_done;
  // A push into a full FIFO is dropped unless the engine frees a slot this cycle.
  assign tx_push    = wb_wr & (wb_adr_i == 3'd3) & (~tx_full | tx_pop);
  // Pop only if data was actually returned in the first cycle of this read.
  assign rx_pop     = wb_acc & ~wb_we_i & (wb_adr_i == 3'd3) & rx_pop_ok_reg;

  assign status     = {busy, nack_reg, al_reg, done_reg, tx_full, tx_empty, rx_full, rx_empty};
  assign bc_en      = en_reg;

  // FIFO storage, no reset so the arrays can map to RAM.
  always_ff @(posedge wb_clk_i) begin
    if (tx_push) tx_mem[tx_wr_ptr_reg] <= wb_dat_i;
    if (rx_push) rx_mem[rx_wr_ptr_reg] <= bc_dout;
  end

  // FIFO pointers and levels.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || flush) begin
      tx_wr_ptr_reg <= '0;
      tx_rd_ptr_reg <= '0;
      tx_cnt_reg    <= '0;
      rx_wr_ptr_reg <= '0;
      rx_rd_ptr_reg <= '0;
      rx_cnt_reg    <= '0;
    end else begin
      if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + PTR_ONE;
      if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + PTR_ONE;
      if (tx_push && !tx_pop)      tx_cnt_reg <= tx_cnt_reg + CNT_ONE;
      else if (!tx_push && tx_pop) tx_cnt_reg <= tx_cnt_reg - CNT_ONE;
      if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + PTR_ONE;
      if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + PTR_ONE;
      if (rx_push && !rx_pop)      rx_cnt_reg <= rx_cnt_reg + CNT_ONE;
      else if (!rx_push && rx_pop) rx_cnt_reg <= rx_cnt_reg - CNT_ONE;
    end
  end

  // Wishbone slave: handshake, register file, read mux, interrupt.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_ack_o      <= 1'b0;
      wb_dat_o      <= 8'h00;
      wb_inta_o     <= 1'b0;
      bc_prer       <= DEFAULT_PRER;
      en_reg        <= 1'b0;
      ien_reg       <= 1'b0;
      sadr_reg      <= DEFAULT_SADR;
      wlen_reg      <= '0;
      rlen_reg      <= '0;
      rx_pop_ok_reg <= 1'b0;
    end else begin
      wb_ack_o  <= wb_req;
      wb_inta_o <= ien_reg & (done_reg | al_reg);
      if (wb_req && !wb_we_i) begin
        rx_pop_ok_reg <= (wb_adr_i == 3'd3) & ~rx_empty;
        case (wb_adr_i)
          3'd0:    wb_dat_o <= bc_prer[7:0];
          3'd1:    wb_dat_o <= bc_prer[15:8];
          3'd2:    wb_dat_o <= {en_reg, ien_reg, 6'b0};
          3'd3:    wb_dat_o <= rx_empty ? 8'h00 : rx_mem[rx_rd_ptr_reg];
          3'd4:    wb_dat_o <= status;
          3'd5:    wb_dat_o <= 8'(wlen_reg);
          3'd6:    wb_dat_o <= 8'(rlen_reg);
          default: wb_dat_o <= {1'b0, sadr_reg};
        endcase
      end
      if (wb_wr) begin
        case (wb_adr_i)
          3'd0: bc_prer[7:0]  <= wb_dat_i;
          3'd1: bc_prer[15:8] <= wb_dat_i;
          3'd2: begin
            en_reg  <= wb_dat_i[7];
            ien_reg <= wb_dat_i[6];
          end
          3'd5: wlen_reg <= LEN_W'(wb_dat_i);
          3'd6: rlen_reg <= LEN_W'(wb_dat_i);
          3'd7: sadr_reg <= wb_dat_i[6:0];
          default: ;
        endcase
      end
    end
  end

  // Transaction sequencer: one byte command per state, held until bc_done.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg  <= IDLE;
      bc_start   <= 1'b0;
      bc_stop    <= 1'b0;
      bc_read    <= 1'b0;
      bc_write   <= 1'b0;
      bc_ack_in  <= 1'b0;
      bc_din     <= 8'h00;
      w_cnt_reg  <= '0;
      r_cnt_reg  <= '0;
      nostop_reg <= 1'b0;
      done_reg   <= 1'b0;
      nack_reg   <= 1'b0;
      al_reg     <= 1'b0;
    end else begin
      // Clear first so a flag set later in this block wins over IACK.
      if (iack) begin
        done_reg <= 1'b0;
        nack_reg <= 1'b0;
        al_reg   <= 1'b0;
      end
      if (abort) begin
        bc_start  <= 1'b0;
        bc_stop   <= 1'b0;
        bc_read   <= 1'b0;
        bc_write  <= 1'b0;
        bc_ack_in <= 1'b0;
        state_reg <= IDLE;
        if (bc_al) begin
          al_reg   <= 1'b1;
          done_reg <= 1'b1;
        end
      end else begin
        case (state_reg)
          IDLE: if (go_accept) begin
            w_cnt_reg  <= wlen_reg;
            r_cnt_reg  <= rlen_reg;
            nostop_reg <= wb_dat_i[6];
            if (wlen_reg != LEN_ZERO)      state_reg <= WADDR;
            else if (rlen_reg != LEN_ZERO) state_reg <= RADDR;
            else                           done_reg  <= 1'b1;
          end
          WADDR, RADDR: begin
            if (!cmd_active) begin
              bc_start <= 1'b1;
              bc_write <= 1'b1;
              bc_din   <= {sadr_reg, (state_reg == RADDR)};
            end else if (bc_done) begin
              bc_start <= 1'b0;
              bc_write <= 1'b0;
              if (bc_rxack) begin
                nack_reg  <= 1'b1;
                state_reg <= STOP;
              end else begin
                state_reg <= (state_reg == RADDR) ? RDATA : WDATA;
              end
            end
          end
          WDATA: begin
            if (!cmd_active) begin
              if (!tx_empty) begin
                bc_write <= 1'b1;
                bc_din   <= tx_mem[tx_rd_ptr_reg];
                bc_stop  <= w_last & (r_cnt_reg == LEN_ZERO) & ~nostop_reg;
              end
            end else if (bc_done) begin
              bc_write <= 1'b0;
              bc_stop  <= 1'b0;
              if (bc_rxack) nack_reg <= 1'b1;
              if (w_last) begin
                if (r_cnt_reg != LEN_ZERO) begin
                  state_reg <= RADDR;
                end else begin
                  state_reg <= IDLE;
                  done_reg  <= 1'b1;
                end
              end else if (bc_rxack) begin
                state_reg <= STOP;
              end else begin
                w_cnt_reg <= w_cnt_reg - LEN_ONE;
              end
            end
          end
          RDATA: begin
            if (!cmd_active) begin
              if (!rx_full) begin
                bc_read   <= 1'b1;
                bc_ack_in <= r_last;
                bc_stop   <= r_last & ~nostop_reg;
              end
            end else if (bc_done) begin
              bc_read   <= 1'b0;
              bc_stop   <= 1'b0;
              bc_ack_in <= 1'b0;
              if (r_last) begin
                state_reg <= IDLE;
                done_reg  <= 1'b1;
              end else begin
                r_cnt_reg <= r_cnt_reg - LEN_ONE;
              end
            end
          end
          STOP: begin
            if (!cmd_active) begin
              bc_stop <= 1'b1;
            end else if (bc_done) begin
              bc_stop   <= 1'b0;
              state_reg <= IDLE;
              done_reg  <= 1'b1;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_fifo_seq.sv
// ---------------------------------------------------------------------------
// tb_i2c_master_fifo_seq
// Directed bench for i2c_master_fifo_seq. A small byte-controller model logs
// every byte command as {start,stop,read,write,ack_in,din} and answers with
// bc_done after a short delay; expected command words and register values
// are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_i2c_master_fifo_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  wb_adr_i;
  logic [7:0]  wb_dat_i, wb_dat_o;
  logic        wb_we_i, wb_stb_i, wb_cyc_i, wb_ack_o, wb_inta_o;
  logic        bc_en;
  logic [15:0] bc_prer;
  logic        bc_start, bc_stop, bc_read, bc_write, bc_ack_in;
  logic [7:0]  bc_din;
  logic        bc_done, bc_rxack, bc_al, bc_busy;
  logic [7:0]  bc_dout;

  always #5 clk = ~clk;

  i2c_master_fifo_seq dut (
    .wb_clk_i (clk),      .wb_rst_i (rst),
    .wb_adr_i (wb_adr_i), .wb_dat_i (wb_dat_i), .wb_dat_o (wb_dat_o),
    .wb_we_i  (wb_we_i),  .wb_stb_i (wb_stb_i), .wb_cyc_i (wb_cyc_i),
    .wb_ack_o (wb_ack_o), .wb_inta_o(wb_inta_o),
    .bc_en    (bc_en),    .bc_prer  (bc_prer),
    .bc_start (bc_start), .bc_stop  (bc_stop),  .bc_read  (bc_read),
    .bc_write (bc_write), .bc_ack_in(bc_ack_in), .bc_din  (bc_din),
    .bc_done  (bc_done),  .bc_rxack (bc_rxack), .bc_dout  (bc_dout),
    .bc_al    (bc_al),    .bc_busy  (bc_busy)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // ---------------- byte-controller model ----------------
  typedef logic [12:0] cmd_t;
  cmd_t       cmd_log[$];
  logic [7:0] rd_q[$];
  bit         nack_addr   = 1'b0;
  int         done_budget = 1000;

  function automatic cmd_t mk(input bit s, input bit p, input bit r, input bit w,
                              input bit a, input logic [7:0] d);
    return {s, p, r, w, a, d};
  endfunction

  initial begin : bc_model
    bc_done = 1'b0; bc_rxack = 1'b0; bc_dout = 8'h00; bc_al = 1'b0; bc_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bc_start | bc_stop | bc_read | bc_write) begin
        cmd_log.push_back({bc_start, bc_stop, bc_read, bc_write,
                           bc_ack_in & bc_read, bc_din & {8{bc_write}}});
        if (done_budget > 0) begin
          done_budget--;
          repeat (2) @(negedge clk);
          bc_rxack = nack_addr & bc_start & bc_write;
          if (bc_read && rd_q.size() > 0) bc_dout = rd_q.pop_front();
          bc_done = 1'b1;
          @(negedge clk);
          bc_done  = 1'b0;
          bc_rxack = 1'b0;
        end else begin
          for (int i = 0; i < 200 && (bc_start | bc_stop | bc_read | bc_write); i++)
            @(negedge clk);
        end
      end
    end
  end

  // ---------------- Wishbone host ----------------
  task automatic wb_xfer(input logic [2:0] a, input logic [7:0] d, input logic we,
                         output logic [7:0] q);
    int n;
    @(negedge clk);
    wb_adr_i = a; wb_dat_i = d; wb_we_i = we; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!wb_ack_o && n < 16);
    if (!wb_ack_o) check_val("wb_ack_timeout", 32'(wb_ack_o), 32'd1);
    q = wb_dat_o;
    @(posedge clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_wr(input logic [2:0] a, input logic [7:0] d);
    logic [7:0] q;
    wb_xfer(a, d, 1'b1, q);
  endtask

  task automatic wb_rd(input logic [2:0] a, output logic [7:0] q);
    wb_xfer(a, 8'h00, 1'b0, q);
  endtask

  task automatic rd_check(input string tag, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] q;
    wb_rd(a, q);
    check_val(tag, 32'(q), 32'(exp));
  endtask

  // Poll STATUS until bit idx reaches val; an expired bound shows as a miscompare.
  task automatic wait_status(input string tag, input int idx, input bit val);
    logic [7:0] q;
    int n;
    n = 0;
    do begin
      wb_rd(3'd4, q); n++;
    end while (q[idx] !== val && n < 300);
    check_val(tag, 32'(q[idx]), 32'(val));
  endtask

  task automatic wait_log(input string tag, input int cnt);
    int n;
    n = 0;
    while (cmd_log.size() < cnt && n < 300) begin
      @(negedge clk); n++;
    end
    check_val(tag, 32'(cmd_log.size()), 32'(cnt));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] q;
    rst = 1'b1; wb_adr_i = 3'd0; wb_dat_i = 8'h00; wb_we_i = 1'b0;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ack",   32'(wb_ack_o), 32'd0);
    check_val("rst_dat",   32'(wb_dat_o), 32'h00);
    check_val("rst_inta",  32'(wb_inta_o), 32'd0);
    check_val("rst_prer",  32'(bc_prer), 32'hffff);
    check_val("rst_cmds",  32'({bc_en, bc_start, bc_stop, bc_read, bc_write, bc_ack_in}), 32'd0);
    check_val("rst_din",   32'(bc_din), 32'h00);
    @(negedge clk); rst = 1'b0;

    // Register reset values and readback
    rd_check("rst_status", 3'd4, 8'h05);
    rd_check("rst_sadr",   3'd7, 8'h7e);
    wb_wr(3'd0, 8'h34);
    wb_wr(3'd1, 8'h12);
    wb_wr(3'd7, 8'h50);
    rd_check("prer_lo", 3'd0, 8'h34);
    rd_check("prer_hi", 3'd1, 8'h12);
    rd_check("sadr",    3'd7, 8'h50);
    check_val("bc_prer", 32'(bc_prer), 32'h1234);
    wb_wr(3'd2, 8'h80);                      // EN
    check_val("bc_en", 32'(bc_en), 32'd1);

    // Write transaction: A5, 3C
    cmd_log.delete();
    wb_wr(3'd3, 8'hA5);
    wb_wr(3'd3, 8'h3C);
    wb_wr(3'd5, 8'd2);
    wb_wr(3'd6, 8'd0);
    wb_wr(3'd4, 8'h80);                      // GO
    wait_status("wr_done", 4, 1'b1);
    check_val("wr_ncmd", 32'(cmd_log.size()), 32'd3);
    check_val("wr_cmd0", 32'(cmd_log[0]), 32'(mk(1, 0, 0, 1, 0, 8'hA0)));
    check_val("wr_cmd1", 32'(cmd_log[1]), 32'(mk(0, 0, 0, 1, 0, 8'hA5)));
    check_val("wr_cmd2", 32'(cmd_log[2]), 32'(mk(0, 1, 0, 1, 0, 8'h3C)));
    rd_check("wr_status", 3'd4, 8'h15);
    check_val("wr_inta_off", 32'(wb_inta_o), 32'd0);
    wb_wr(3'd2, 8'hC0);                      // EN + IEN
    repeat (2) @(posedge clk); #1;
    check_val("wr_inta_on", 32'(wb_inta_o), 32'd1);
    wb_wr(3'd4, 8'h01);                      // IACK
    repeat (2) @(posedge clk); #1;
    check_val("wr_inta_iack", 32'(wb_inta_o), 32'd0);

    // Write-then-read with repeated start
    cmd_log.delete();
    rd_q = '{8'h11, 8'h22, 8'h33};
    wb_wr(3'd3, 8'h10);
    wb_wr(3'd5, 8'd1);
    wb_wr(3'd6, 8'd3);
    wb_wr(3'd4, 8'h80);
    wait_status("wrd_done", 4, 1'b1);
    check_val("wrd_ncmd", 32'(cmd_log.size()), 32'd6);
    check_val("wrd_cmd0", 32'(cmd_log[0]), 32'(mk(1, 0, 0, 1, 0, 8'hA0)));
    check_val("wrd_cmd1", 32'(cmd_log[1]), 32'(mk(0, 0, 0, 1, 0, 8'h10)));
    check_val("wrd_cmd2", 32'(cmd_log[2]), 32'(mk(1, 0, 0, 1, 0, 8'hA1)));
    check_val("wrd_cmd3", 32'(cmd_log[3]), 32'(mk(0, 0, 1, 0, 0, 8'h00)));
    check_val("wrd_cmd4", 32'(cmd_log[4]), 32'(mk(0, 0, 1, 0, 0, 8'h00)));
    check_val("wrd_cmd5", 32'(cmd_log[5]), 32'(mk(0, 1, 1, 0, 1, 8'h00)));
    rd_check("wrd_status", 3'd4, 8'h14);
    rd_check("wrd_pop0", 3'd3, 8'h11);
    rd_check("wrd_pop1", 3'd3, 8'h22);
    rd_check("wrd_pop2", 3'd3, 8'h33);
    rd_check("wrd_pop_empty", 3'd3, 8'h00);
    wb_wr(3'd4, 8'h01);
    rd_check("wrd_status_iack", 3'd4, 8'h05);

    // Address NACK -> stop-only, TX byte left in FIFO
    cmd_log.delete();
    nack_addr = 1'b1;
    wb_wr(3'd3, 8'h77);
    wb_wr(3'd5, 8'd1);
    wb_wr(3'd6, 8'd0);
    wb_wr(3'd4, 8'h80);
    wait_status("nak_done", 4, 1'b1);
    nack_addr = 1'b0;
    check_val("nak_ncmd", 32'(cmd_log.size()), 32'd2);
    check_val("nak_cmd0", 32'(cmd_log[0]), 32'(mk(1, 0, 0, 1, 0, 8'hA0)));
    check_val("nak_cmd1", 32'(cmd_log[1]), 32'(mk(0, 1, 0, 0, 0, 8'h00)));
    rd_check("nak_status", 3'd4, 8'h51);
    wb_wr(3'd2, 8'hC1);                      // flush, keep EN/IEN
    wb_wr(3'd4, 8'h01);
    rd_check("nak_flushed", 3'd4, 8'h05);

    // RX stall at FIFO full, resumed by host pops
    cmd_log.delete();
    rd_q.delete();
    for (int i = 1; i <= 10; i++) rd_q.push_back(8'(i));
    wb_wr(3'd5, 8'd0);
    wb_wr(3'd6, 8'd10);
    wb_wr(3'd4, 8'h80);
    wait_status("stl_rxfull", 1, 1'b1);
    repeat (40) @(posedge clk);
    check_val("stl_ncmd", 32'(cmd_log.size()), 32'd9);
    rd_check("stl_status", 3'd4, 8'h86);
    for (int i = 1; i <= 8; i++) rd_check($sformatf("stl_pop%0d", i), 3'd3, 8'(i));
    wait_status("stl_done", 4, 1'b1);
    rd_check("stl_pop9",  3'd3, 8'd9);
    rd_check("stl_pop10", 3'd3, 8'd10);
    rd_check("stl_pop_empty", 3'd3, 8'h00);
    check_val("stl_ncmd_end", 32'(cmd_log.size()), 32'd11);
    check_val("stl_last_cmd", 32'(cmd_log[10]), 32'(mk(0, 1, 1, 0, 1, 8'h00)));
    wb_wr(3'd4, 8'h01);

    // TX overflow: 9 pushes keep 8 entries; 9th byte never sent
    cmd_log.delete();
    for (int i = 0; i < 9; i++) wb_wr(3'd3, 8'(8'h40 + i));
    rd_check("ovf_status", 3'd4, 8'h09);
    wb_wr(3'd5, 8'd8);
    wb_wr(3'd6, 8'd0);
    wb_wr(3'd4, 8'h80);
    wait_status("ovf_done", 4, 1'b1);
    check_val("ovf_ncmd", 32'(cmd_log.size()), 32'd9);
    check_val("ovf_cmd1", 32'(cmd_log[1]), 32'(mk(0, 0, 0, 1, 0, 8'h40)));
    check_val("ovf_cmd8", 32'(cmd_log[8]), 32'(mk(0, 1, 0, 1, 0, 8'h47)));
    rd_check("ovf_status_end", 3'd4, 8'h15);
    wb_wr(3'd4, 8'h01);

    // Arbitration lost during WDATA
    cmd_log.delete();
    done_budget = 1;
    wb_wr(3'd3, 8'h61);
    wb_wr(3'd3, 8'h62);
    wb_wr(3'd5, 8'd2);
    wb_wr(3'd4, 8'h80);
    wait_log("al_wdata_cmd", 2);
    check_val("al_cmd1", 32'(cmd_log[1]), 32'(mk(0, 0, 0, 1, 0, 8'h61)));
    @(negedge clk); bc_al = 1'b1;
    @(posedge clk); #1;
    check_val("al_cmds_low", 32'({bc_start, bc_stop, bc_read, bc_write}), 32'd0);
    @(negedge clk); bc_al = 1'b0;
    repeat (20) @(posedge clk);
    done_budget = 1000;
    check_val("al_no_stop", 32'(cmd_log.size()), 32'd2);
    rd_check("al_status", 3'd4, 8'h31);
    wb_wr(3'd4, 8'h01);
    wb_wr(3'd2, 8'h81);                      // flush
    wb_wr(3'd2, 8'h00);                      // EN=0

    // GO with EN=0 is ignored
    wb_wr(3'd3, 8'h55);
    wb_wr(3'd5, 8'd1);
    wb_wr(3'd4, 8'h80);
    repeat (20) @(posedge clk);
    rd_check("noen_status", 3'd4, 8'h01);
    check_val("noen_ncmd", 32'(cmd_log.size()), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/i2c_master_fifo_seq.md
Name: i2c_master_fifo_seq

Overview:
- Wishbone-attached I2C transaction sequencer with parametrised TX/RX FIFOs.
- Sits between the Wishbone slave port and i2c_master_byte_ctrl; drives one byte command at a time and handles each byte command's completion itself.
- Executes a full write/repeated-start/read transaction from a single GO, so firmware no longer services every byte.
- Adds FIFO buffering, length counters, auto-ACK/NACK and auto-STOP.

Parameters:
- FIFO_DEPTH, 8, entries per FIFO; power of 2, range 2..16.
- FIFO_AW, 3, log2(FIFO_DEPTH).
- LEN_W, 8, width of the WLEN/RLEN byte counters.
- DEFAULT_PRER, 16'hffff, prescale reset value.
- DEFAULT_SADR, 7'h7e, slave address reset value.

Ports:
- wb_clk_i  in  1  single clock
- wb_rst_i  in  1  reset, synchronous, active-high
- wb_adr_i  in  3  register select
- wb_dat_i  in  8  write data
- wb_dat_o  out 8  registered read data
- wb_we_i  in  1  write enable
- wb_stb_i  in  1  strobe
- wb_cyc_i  in  1  cycle
- wb_ack_o  out 1  acknowledge
- wb_inta_o  out 1  interrupt, registered
- bc_en  out 1  CTRL.EN
- bc_prer  out 16  prescale value
- bc_start, bc_stop, bc_read, bc_write  out 1 each  byte command bits, held until bc_done
- bc_ack_in  out 1  ACK bit sent after a read (1 = NACK)
- bc_din  out 8  byte to transmit
- bc_done  in  1  one-cycle command-complete pulse
- bc_rxack  in  1  received ACK (1 = NACK)
- bc_dout  in  8  received byte
- bc_al  in  1  arbitration-lost pulse
- bc_busy  in  1  bus busy

Behaviour:
- Reset values: wb_ack_o=0, wb_dat_o=0, wb_inta_o=0, all bc_* command outputs=0, bc_din=0, bc_prer=DEFAULT_PRER, CTRL=0, SADR=DEFAULT_SADR, WLEN=RLEN=0, FIFOs empty, all flags 0, FSM=IDLE.
- Wishbone handshake: wb_ack_o <= cyc & stb & ~wb_ack_o, giving one wait state. Register writes and RX pops take effect in the cycle where wb_ack_o & cyc & stb.
- Register map, writes:
  - 0 PRER[7:0]; 1 PRER[15:8]
  - 2 CTRL: [7] EN, [6] IEN, [0] FLUSH (self-clearing; applied only in IDLE)
  - 3 push TX FIFO
  - 4 CMD: [7] GO, [6] NOSTOP, [0] IACK (clears DONE/NACK/AL)
  - 5 WLEN; 6 RLEN; 7 SADR[6:0]
- Register map, reads:
  - 0/1 PRER; 2 CTRL
  - 3 pop RX FIFO; empty returns 0x00 and pointers are unchanged
  - 4 STATUS {BUSY, NACK, AL, DONE, TXFULL, TXEMPTY, RXFULL, RXEMPTY}
  - 5 WLEN; 6 RLEN; 7 {0,SADR}
- FIFO boundaries: a push to a full TX FIFO is dropped. Host push and engine pop in the same cycle both occur, level unchanged; same rule for RX.
- GO handling: GO is accepted only when IDLE and EN=1, otherwise ignored. On accept, WLEN/RLEN/NOSTOP are latched into internal counters/flags; later register writes affect only the next transaction.
- FSM, one byte command per state; bc_* held until bc_done:
  - IDLE: on GO, go to WADDR if WLEN>0, else RADDR if RLEN>0. If both are 0, set DONE immediately with no bus activity.
  - WADDR: start+write, din={SADR,0}. On done: NACK -> STOP, else WDATA.
  - WDATA: if TX empty, stall with no command asserted; else pop and write.
    - Stop bit is set on the last byte when RLEN=0 and NOSTOP=0.
    - On done, NACK on a non-last byte -> STOP.
    - Last byte: go to RADDR if RLEN>0, else IDLE.
  - RADDR: start (repeated start if a write phase ran) + write, din={SADR,1}. On done: NACK -> STOP, else RDATA.
  - RDATA: if RX full, stall with no command asserted; else read.
    - bc_ack_in=1 on the last byte only.
    - Stop bit is set on the last byte when NOSTOP=0.
    - On done, push bc_dout; last byte -> IDLE.
  - STOP: stop-only command; on done -> IDLE.
- Flags:
  - NACK: sticky, set on any bc_rxack=1 during a write command.
  - DONE: set on every return to IDLE from a transaction.
- Arbitration lost: bc_al in any non-IDLE state drops commands the next cycle, goes to IDLE, sets AL and DONE, issues no STOP.
- EN cleared mid-transaction: commands drop, FSM goes to IDLE, flags and FIFOs are kept.
- wb_rst_i mid-transaction: full reset next edge, FIFOs emptied.
- BUSY = FSM != IDLE.
- wb_inta_o <= IEN & (DONE | AL). IACK together with a flag set in the same cycle: set wins.

Test Plan:
- Register reset/readback: reset, write PRER=0x1234 and SADR=0x50, read back -> 0x34, 0x12, 0x50; STATUS=0x05.
- Write transaction: push A5, 3C; WLEN=2, RLEN=0, GO, model ACKs all -> commands:
  - start+write din=0xA0
  - write 0xA5
  - write+stop 0x3C
  - then DONE=1, TXEMPTY=1; IEN=1 gives wb_inta_o=1; IACK clears it.
- Write-then-read: WLEN=1 (push 0x10), RLEN=3, model returns 11,22,33 -> RADDR issues start with din=0xA1; reads send ack_in 0,0,1 with stop on the 3rd; RX pops return 11,22,33 then 00.
- Address NACK: model NACKs the address byte -> STOP state issues stop-only, NACK=1, DONE=1, TX FIFO untouched.
- Stall/overflow:
  - FIFO_DEPTH=8, RLEN=10, no host pops -> engine stalls after 8 bytes with RXFULL=1; popping one resumes the read.
  - 9 pushes to an empty TX FIFO keep level at 8.
- Abort: bc_al pulse during WDATA -> commands low next cycle, AL=1, no stop; GO with EN=0 is ignored, BUSY stays 0.
